// File: rtl/axi_packet_if.sv
// axi_packet_if
//   Bundles the request/descriptor/beat/coverage signals of the axi_packet
//   stimulus generator.
//   master modport : the generator (drives descriptor, beats, counters)
//   slave modport  : the consumer (drives gen_req, pkt_ack, beat_ready)
//   Signals:
//     gen_req, pkt_ack, beat_ready        consumer -> generator
//     pkt_valid, access, addr, len, size  descriptor
//     inlimit, exp_resp                   descriptor classification
//     beat_valid, beat_data, beat_last    write data stream
//     cnt_write/read/inlimit/outlimit     saturating coverage counters
interface axi_packet_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);
  logic                  gen_req;
  logic                  pkt_valid;
  logic                  pkt_ack;
  logic                  access;
  logic [ADDR_WIDTH-1:0] addr;
  logic [7:0]            len;
  logic [2:0]            size;
  logic                  inlimit;
  logic [1:0]            exp_resp;
  logic                  beat_valid;
  logic                  beat_ready;
  logic [DATA_WIDTH-1:0] beat_data;
  logic                  beat_last;
  logic [15:0]           cnt_write;
  logic [15:0]           cnt_read;
  logic [15:0]           cnt_inlimit;
  logic [15:0]           cnt_outlimit;

  modport master (
    input  gen_req, pkt_ack, beat_ready,
    output pkt_valid, access, addr, len, size, inlimit, exp_resp,
           beat_valid, beat_data, beat_last,
           cnt_write, cnt_read, cnt_inlimit, cnt_outlimit
  );

  modport slave (
    output gen_req, pkt_ack, beat_ready,
    input  pkt_valid, access, addr, len, size, inlimit, exp_resp,
           beat_valid, beat_data, beat_last,
           cnt_write, cnt_read, cnt_inlimit, cnt_outlimit
  );
endinterface

// File: rtl/axi_packet.sv
// axi_packet
//   Randomised AXI4 transaction descriptor generator driven by a 32-bit
//   Galois LFSR. One descriptor per gen_req; write descriptors also stream
//   len+1 data beats taken from successive LFSR states. Keeps saturating
//   coverage counters of completed packets.
//   Ports:
//     ACLK   : clock, rising edge
//     ARESET : synchronous active-high reset
//     bus    : axi_packet_if.master (request, descriptor, beats, counters)
//   DATA_WIDTH must be 32; MEMORY_DEPTH must be a power of two with
//   MEMORY_DEPTH*8 <= 2**ADDR_WIDTH.
module axi_packet #(
  parameter int          ADDR_WIDTH   = 16,
  parameter int          DATA_WIDTH   = 32,
  parameter int          MEMORY_DEPTH = 1024,
  parameter logic [31:0] SEED         = 32'h1
) (
  input  logic          ACLK,
  input  logic          ARESET,
  axi_packet_if.master  bus
);

  typedef enum logic {IDLE, PKT} state_t;

  localparam logic [31:0] LFSR_TAPS  = 32'h80200003;
  // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
  localparam logic [31:0] LFSR_INIT  = (SEED == 32'h0) ? 32'h1 : SEED;
  localparam logic [31:0] DEPTH      = 32'(MEMORY_DEPTH);
  localparam logic [31:0] PAGE_WORDS = 32'd1024;

  function automatic logic [31:0] lfsrStep(input logic [31:0] l);
    logic [31:0] n;
    n = l >> 1;
    if (l[0]) n = n ^ LFSR_TAPS;
    return n;
  endfunction

  function automatic logic [15:0] satInc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  state_t                state_q;
  logic [31:0]           lfsr_q;
  logic                  access_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            len_q;
  logic                  inlimit_q;
  logic [1:0]            expResp_q;
  logic                  pktValid_q;
  logic                  beatValid_q;
  logic                  beatLast_q;
  logic [7:0]            beatIdx_q;
  logic                  writeDone_q;
  logic [15:0]           cntWrite_q;
  logic [15:0]           cntRead_q;
  logic [15:0]           cntInlimit_q;
  logic [15:0]           cntOutlimit_q;

  logic [31:0]           r_d;
  logic [31:0]           word_d;
  logic [31:0]           rawLen_d;
  logic [31:0]           room_d;
  logic [31:0]           pageRoom_d;
  logic [31:0]           lenFull_d;
  logic [31:0]           startWord_d;
  logic                  access_d;
  logic                  inlimit_d;
  logic [7:0]            len_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [1:0]            expResp_d;
  logic                  beatFire;
  logic                  ackFire;

  // Descriptor that a request in IDLE would latch, derived from the next
  // LFSR state. In-limit bursts are clamped to whichever is tighter: the
  // end of memory or the end of the current 4 KB (1024-word) page.
  always_comb begin
    r_d        = lfsrStep(lfsr_q);
    access_d   = r_d[0];
    inlimit_d  = (r_d & 32'h6) != 32'h0;
    rawLen_d   = (r_d >> 4) & 32'hFF;
    word_d     = (r_d >> 16) & (DEPTH - 32'd1);
    room_d     = DEPTH - word_d;
    pageRoom_d = PAGE_WORDS - (word_d & (PAGE_WORDS - 32'd1));
    if (pageRoom_d < room_d) room_d = pageRoom_d;
    if (inlimit_d) begin
      lenFull_d   = (rawLen_d >= room_d) ? room_d - 32'd1 : rawLen_d;
      startWord_d = word_d;
      expResp_d   = 2'b00;
    end else begin
      lenFull_d   = rawLen_d;
      startWord_d = DEPTH + word_d;
      expResp_d   = 2'b10;
    end
    len_d  = 8'(lenFull_d);
    addr_d = ADDR_WIDTH'(startWord_d << 2);
  end

  // An ack is only honoured once a write has delivered every beat; the
  // final beat handshake and the ack may coincide.
  assign beatFire = beatValid_q & bus.beat_ready;
  assign ackFire  = (state_q == PKT) & bus.pkt_ack &
                    (access_q | writeDone_q | (beatFire & beatLast_q));

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q       <= IDLE;
      lfsr_q        <= LFSR_INIT;
      access_q      <= 1'b0;
      addr_q        <= '0;
      len_q         <= 8'd0;
      inlimit_q     <= 1'b0;
      expResp_q     <= 2'b00;
      pktValid_q    <= 1'b0;
      beatValid_q   <= 1'b0;
      beatLast_q    <= 1'b0;
      beatIdx_q     <= 8'd0;
      writeDone_q   <= 1'b0;
      cntWrite_q    <= 16'd0;
      cntRead_q     <= 16'd0;
      cntInlimit_q  <= 16'd0;
      cntOutlimit_q <= 16'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.gen_req) begin
            state_q     <= PKT;
            lfsr_q      <= r_d;
            access_q    <= access_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            inlimit_q   <= inlimit_d;
            expResp_q   <= expResp_d;
            pktValid_q  <= 1'b1;
            beatValid_q <= ~access_d;
            beatLast_q  <= ~access_d & (len_d == 8'd0);
            beatIdx_q   <= 8'd0;
            writeDone_q <= access_d;
          end
        end
        PKT: begin
          // Each accepted beat advances the LFSR so the next beat carries
          // the following pseudo-random word.
          if (beatFire) begin
            lfsr_q <= lfsrStep(lfsr_q);
            if (beatLast_q) begin
              beatValid_q <= 1'b0;
              beatLast_q  <= 1'b0;
              writeDone_q <= 1'b1;
            end else begin
              beatIdx_q  <= beatIdx_q + 8'd1;
              beatLast_q <= (beatIdx_q + 8'd1 == len_q);
            end
          end
          if (ackFire) begin
            state_q     <= IDLE;
            pktValid_q  <= 1'b0;
            beatValid_q <= 1'b0;
            beatLast_q  <= 1'b0;
            if (access_q) cntRead_q <= satInc(cntRead_q);
            else          cntWrite_q <= satInc(cntWrite_q);
            if (inlimit_q) cntInlimit_q <= satInc(cntInlimit_q);
            else           cntOutlimit_q <= satInc(cntOutlimit_q);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.pkt_valid    = pktValid_q;
  assign bus.access       = access_q;
  assign bus.addr         = addr_q;
  assign bus.len          = len_q;
  assign bus.size         = 3'b010;
  assign bus.inlimit      = inlimit_q;
  assign bus.exp_resp     = expResp_q;
  assign bus.beat_valid   = beatValid_q;
  // The LFSR is nonzero after reset, so data is gated to read as zero
  // whenever no beat is offered.
  assign bus.beat_data    = beatValid_q ? lfsr_q[DATA_WIDTH-1:0] : '0;
  assign bus.beat_last    = beatLast_q;
  assign bus.cnt_write    = cntWrite_q;
  assign bus.cnt_read     = cntRead_q;
  assign bus.cnt_inlimit  = cntInlimit_q;
  assign bus.cnt_outlimit = cntOutlimit_q;

endmodule

// File: tb/tb_axi_packet.sv
// tb_axi_packet
//   Self-checking bench for axi_packet (SEED = 0). A bench-side LFSR model
//   predicts every descriptor and write beat; predictions are queued when a
//   request is driven and popped when the DUT presents the packet.
module tb_axi_packet;
  localparam int AW  = 16;
  localparam int MEM = 1024;

  typedef struct packed {
    logic          access;
    logic [AW-1:0] addr;
    logic [7:0]    len;
    logic [2:0]    size;
    logic          inlimit;
    logic [1:0]    resp;
  } desc_t;

  logic ACLK = 1'b0;
  logic ARESET;

  axi_packet_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) bus ();

  axi_packet #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (32),
    .MEMORY_DEPTH(MEM),
    .SEED        (32'h0)
  ) dut (
    .ACLK  (ACLK),
    .ARESET(ARESET),
    .bus   (bus)
  );

  always #5 ACLK = ~ACLK;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] mLfsr;
  desc_t       descQ[$];
  logic [31:0] beatQ[$];
  int          nWr, nRd, nIn, nOut;

  // Reference LFSR step written in shift/xor form independently of the DUT.
  function automatic logic [31:0] modelStep(input logic [31:0] v);
    logic [31:0] n;
    n = {1'b0, v[31:1]};
    if (v[0]) n = n ^ 32'h80200003;
    return n;
  endfunction

  function automatic desc_t modelDesc(input logic [31:0] r);
    desc_t d;
    int    w, lim, rl;
    w         = int'(r[31:16]) % MEM;
    rl        = int'(r[11:4]);
    d.access  = r[0];
    d.size    = 3'b010;
    d.inlimit = (r[2:1] != 2'b00);
    if (d.inlimit) begin
      lim = MEM - w;
      if (1024 - (w % 1024) < lim) lim = 1024 - (w % 1024);
      if (rl > lim - 1) rl = lim - 1;
      d.len  = 8'(rl);
      d.addr = AW'(w * 4);
      d.resp = 2'b00;
    end else begin
      d.len  = 8'(rl);
      d.addr = AW'((MEM + w) * 4);
      d.resp = 2'b10;
    end
    return d;
  endfunction

  function automatic desc_t sampleDesc();
    return {bus.access, bus.addr, bus.len, bus.size, bus.inlimit, bus.exp_resp};
  endfunction

  task automatic noteDone(input desc_t d);
    if (d.access) nRd++; else nWr++;
    if (d.inlimit) nIn++; else nOut++;
  endtask

  // Advance the model for one accepted request and queue its expectations.
  task automatic modelRequest(output desc_t d);
    logic [31:0] b;
    mLfsr = modelStep(mLfsr);
    d     = modelDesc(mLfsr);
    descQ.push_back(d);
    if (!d.access) begin
      b = mLfsr;
      for (int i = 0; i <= int'(d.len); i++) begin
        beatQ.push_back(b);
        b = modelStep(b);
      end
      mLfsr = b;
    end
  endtask

  task automatic startPacket();
    desc_t d;
    @(negedge ACLK);
    bus.gen_req = 1'b1;
    modelRequest(d);
    @(negedge ACLK);
    bus.gen_req = 1'b0;
  endtask

  // Drain beats and ack without checking; used only to steer the LFSR.
  task automatic finishPacket(input desc_t d, output bit timedOut);
    logic [31:0] junk;
    int          k;
    timedOut = 1'b0;
    bus.beat_ready = 1'b1;
    if (!d.access) begin
      for (k = 0; k < 300; k++) begin
        if (bus.beat_valid === 1'b1) begin
          junk = beatQ.pop_front();
          if (bus.beat_last === 1'b1) break;
        end
        @(negedge ACLK);
      end
      if (k >= 300) timedOut = 1'b1;
    end
    bus.pkt_ack = 1'b1;
    @(negedge ACLK);
    bus.pkt_ack = 1'b0;
    noteDone(d);
  endtask

  task automatic runPacket(output desc_t d, output bit timedOut);
    startPacket();
    d = descQ.pop_front();
    finishPacket(d, timedOut);
  endtask

  task automatic waitForAccess(input logic want, output bit timedOut);
    logic [31:0] nxt;
    desc_t       d;
    bit          t;
    timedOut = 1'b1;
    for (int i = 0; i < 40; i++) begin
      nxt = modelStep(mLfsr);
      if (nxt[0] == want) begin
        timedOut = 1'b0;
        break;
      end
      runPacket(d, t);
      if (t) break;
    end
  endtask

  task automatic test_reset();
    bus.gen_req = 1'b0; bus.pkt_ack = 1'b0; bus.beat_ready = 1'b0;
    ARESET = 1'b1;
    repeat (2) @(negedge ACLK);
    checks++;
    if (sampleDesc() !== desc_t'({1'b0, 16'h0, 8'h0, 3'b010, 1'b0, 2'b00})) begin
      failures++;
      $display("[TB] FAIL reset_desc: got %h expected %h", sampleDesc(),
               desc_t'({1'b0, 16'h0, 8'h0, 3'b010, 1'b0, 2'b00}));
    end
    checks++;
    if ({bus.pkt_valid, bus.beat_valid, bus.beat_last, bus.beat_data} !== 35'h0) begin
      failures++;
      $display("[TB] FAIL reset_flags: got %h expected 0",
               {bus.pkt_valid, bus.beat_valid, bus.beat_last, bus.beat_data});
    end
    checks++;
    if ({bus.cnt_write, bus.cnt_read, bus.cnt_inlimit, bus.cnt_outlimit} !== 64'h0) begin
      failures++;
      $display("[TB] FAIL reset_counters: got %h expected 0",
               {bus.cnt_write, bus.cnt_read, bus.cnt_inlimit, bus.cnt_outlimit});
    end
    ARESET = 1'b0;
    mLfsr = 32'h1;
    // Abandon a packet with reset: nothing may be counted.
    startPacket();
    checks++;
    if (bus.pkt_valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL midreset_start: pkt_valid got %b expected 1", bus.pkt_valid);
    end
    bus.pkt_ack = 1'b1; bus.beat_ready = 1'b1;
    ARESET = 1'b1;
    repeat (2) @(negedge ACLK);
    bus.pkt_ack = 1'b0; bus.beat_ready = 1'b0;
    ARESET = 1'b0;
    checks++;
    if ({bus.pkt_valid, bus.cnt_write, bus.cnt_read, bus.cnt_inlimit, bus.cnt_outlimit} !== 65'h0) begin
      failures++;
      $display("[TB] FAIL midreset_abandon: got %h expected 0",
               {bus.pkt_valid, bus.cnt_write, bus.cnt_read, bus.cnt_inlimit, bus.cnt_outlimit});
    end
    descQ.delete(); beatQ.delete();
    mLfsr = 32'h1;
    nWr = 0; nRd = 0; nIn = 0; nOut = 0;
  endtask

  task automatic test_first_packet();
    desc_t d;
    bit    t;
    startPacket();
    d = descQ.pop_front();
    checks++;
    if (bus.pkt_valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL first_latency: pkt_valid got %b expected 1", bus.pkt_valid);
    end
    checks++;
    if (sampleDesc() !== desc_t'({1'b1, 16'h0080, 8'h00, 3'b010, 1'b1, 2'b00})) begin
      failures++;
      $display("[TB] FAIL first_desc: got %h expected %h", sampleDesc(),
               desc_t'({1'b1, 16'h0080, 8'h00, 3'b010, 1'b1, 2'b00}));
    end
    finishPacket(d, t);
    checks++;
    if ({bus.pkt_valid, bus.cnt_read, bus.cnt_inlimit} !== {1'b0, 16'd1, 16'd1}) begin
      failures++;
      $display("[TB] FAIL first_done: got valid=%b rd=%0d in=%0d expected 0/1/1",
               bus.pkt_valid, bus.cnt_read, bus.cnt_inlimit);
    end
  endtask

  task automatic test_random_packets();
    desc_t       d;
    logic [31:0] eb;
    int          idx, a, bytes;
    bus.beat_ready = 1'b1;
    for (int n = 0; n < 200; n++) begin
      startPacket();
      d = descQ.pop_front();
      checks++;
      if (bus.pkt_valid !== 1'b1) begin
        failures++;
        $display("[TB] FAIL rand_latency pkt%0d: pkt_valid got %b expected 1", n, bus.pkt_valid);
      end
      checks++;
      if (sampleDesc() !== d) begin
        failures++;
        $display("[TB] FAIL rand_desc pkt%0d: got %h expected %h", n, sampleDesc(), d);
      end
      a     = int'(bus.addr);
      bytes = 4 * (int'(bus.len) + 1);
      checks++;
      if (bus.inlimit === 1'b1) begin
        if (a + bytes > 4096 || (a % 4096) + bytes > 4096 || bus.exp_resp !== 2'b00) begin
          failures++;
          $display("[TB] FAIL rand_inlimit pkt%0d: addr=%h len=%0d resp=%b expected in range, resp 00",
                   n, bus.addr, bus.len, bus.exp_resp);
        end
      end else begin
        if (a < 'h1000 || a > 'h1FFC || bus.exp_resp !== 2'b10) begin
          failures++;
          $display("[TB] FAIL rand_outlimit pkt%0d: addr=%h resp=%b expected 1000..1FFC, resp 10",
                   n, bus.addr, bus.exp_resp);
        end
      end
      idx = 0;
      if (!d.access) begin
        for (int k = 0; k < 300 && idx <= int'(d.len); k++) begin
          if (bus.beat_valid === 1'b1) begin
            eb = beatQ.pop_front();
            checks++;
            if (bus.beat_data !== eb || bus.beat_last !== (idx == int'(d.len))) begin
              failures++;
              $display("[TB] FAIL rand_beat pkt%0d beat%0d: got %h last=%b expected %h last=%b",
                       n, idx, bus.beat_data, bus.beat_last, eb, idx == int'(d.len));
            end
            idx++;
          end
          if (idx <= int'(d.len)) @(negedge ACLK);
        end
        checks++;
        if (idx != int'(d.len) + 1) begin
          failures++;
          $display("[TB] FAIL rand_beat_count pkt%0d: got %0d expected %0d", n, idx, int'(d.len) + 1);
        end
      end
      bus.pkt_ack = 1'b1;
      @(negedge ACLK);
      bus.pkt_ack = 1'b0;
      noteDone(d);
      checks++;
      if (bus.pkt_valid !== 1'b0 || bus.beat_valid !== 1'b0) begin
        failures++;
        $display("[TB] FAIL rand_complete pkt%0d: valid=%b beat_valid=%b expected 0/0",
                 n, bus.pkt_valid, bus.beat_valid);
      end
    end
    checks++;
    if ({bus.cnt_write, bus.cnt_read, bus.cnt_inlimit, bus.cnt_outlimit} !==
        {16'(nWr), 16'(nRd), 16'(nIn), 16'(nOut)}) begin
      failures++;
      $display("[TB] FAIL rand_counters: got w=%0d r=%0d in=%0d out=%0d expected %0d %0d %0d %0d",
               bus.cnt_write, bus.cnt_read, bus.cnt_inlimit, bus.cnt_outlimit, nWr, nRd, nIn, nOut);
    end
    checks++;
    if (int'(bus.cnt_write) + int'(bus.cnt_read) != int'(bus.cnt_inlimit) + int'(bus.cnt_outlimit)) begin
      failures++;
      $display("[TB] FAIL rand_counter_sum: got wr+rd=%0d expected in+out=%0d",
               int'(bus.cnt_write) + int'(bus.cnt_read), int'(bus.cnt_inlimit) + int'(bus.cnt_outlimit));
    end
  endtask

  task automatic test_write_beats();
    desc_t       d;
    logic [31:0] eb;
    bit          t;
    int          idx, lastSeen;
    logic [15:0] wr0;
    waitForAccess(1'b0, t);
    checks++;
    if (t) begin
      failures++;
      $display("[TB] FAIL wb_find_write: timeout got 1 expected 0");
    end
    bus.beat_ready = 1'b1;
    wr0 = bus.cnt_write;
    startPacket();
    d = descQ.pop_front();
    idx = 0; lastSeen = 0;
    for (int k = 0; k < 300 && idx <= int'(d.len); k++) begin
      if (bus.beat_valid === 1'b1) begin
        eb = beatQ.pop_front();
        if (bus.beat_last === 1'b1) lastSeen++;
        checks++;
        if (bus.beat_data !== eb || bus.beat_last !== (idx == int'(d.len))) begin
          failures++;
          $display("[TB] FAIL wb_beat beat%0d: got %h last=%b expected %h last=%b",
                   idx, bus.beat_data, bus.beat_last, eb, idx == int'(d.len));
        end
        idx++;
      end
      @(negedge ACLK);
    end
    checks++;
    if (idx != int'(d.len) + 1 || lastSeen != 1) begin
      failures++;
      $display("[TB] FAIL wb_count: got beats=%0d lasts=%0d expected %0d/1", idx, lastSeen, int'(d.len) + 1);
    end
    checks++;
    if ({bus.beat_valid, bus.pkt_valid, bus.cnt_write} !== {1'b0, 1'b1, wr0}) begin
      failures++;
      $display("[TB] FAIL wb_after_last: got bv=%b pv=%b wr=%0d expected 0/1/%0d",
               bus.beat_valid, bus.pkt_valid, bus.cnt_write, wr0);
    end
    bus.pkt_ack = 1'b1;
    @(negedge ACLK);
    bus.pkt_ack = 1'b0;
    noteDone(d);
    checks++;
    if ({bus.pkt_valid, bus.cnt_write} !== {1'b0, wr0 + 16'd1}) begin
      failures++;
      $display("[TB] FAIL wb_ack: got pv=%b wr=%0d expected 0/%0d", bus.pkt_valid, bus.cnt_write, wr0 + 16'd1);
    end
  endtask

  task automatic test_early_ack();
    desc_t       d;
    logic [31:0] eb;
    bit          t;
    int          idx;
    logic [63:0] cnt0;
    waitForAccess(1'b0, t);
    checks++;
    if (t) begin
      failures++;
      $display("[TB] FAIL ea_find_write: timeout got 1 expected 0");
    end
    bus.beat_ready = 1'b0;
    cnt0 = {bus.cnt_write, bus.cnt_read, bus.cnt_inlimit, bus.cnt_outlimit};
    startPacket();
    d = descQ.pop_front();
    bus.pkt_ack = 1'b1;
    repeat (3) begin
      @(negedge ACLK);
      checks++;
      if (bus.pkt_valid !== 1'b1 ||
          {bus.cnt_write, bus.cnt_read, bus.cnt_inlimit, bus.cnt_outlimit} !== cnt0) begin
        failures++;
        $display("[TB] FAIL ea_ignored: got pv=%b cnts=%h expected 1/%h", bus.pkt_valid,
                 {bus.cnt_write, bus.cnt_read, bus.cnt_inlimit, bus.cnt_outlimit}, cnt0);
      end
    end
    idx = 0;
    for (int k = 0; k < 2000 && idx <= int'(d.len); k++) begin
      bus.beat_ready = 1'($urandom_range(0, 1));
      checks++;
      if (bus.pkt_valid !== 1'b1) begin
        failures++;
        $display("[TB] FAIL ea_held beat%0d: pkt_valid got %b expected 1", idx, bus.pkt_valid);
      end
      if (bus.beat_valid === 1'b1 && bus.beat_ready) begin
        eb = beatQ.pop_front();
        checks++;
        if (bus.beat_data !== eb) begin
          failures++;
          $display("[TB] FAIL ea_beat beat%0d: got %h expected %h", idx, bus.beat_data, eb);
        end
        idx++;
      end
      @(negedge ACLK);
    end
    bus.pkt_ack = 1'b0;
    noteDone(d);
    checks++;
    if (idx != int'(d.len) + 1 || bus.pkt_valid !== 1'b0 || bus.cnt_write !== cnt0[63:48] + 16'd1) begin
      failures++;
      $display("[TB] FAIL ea_complete: got beats=%0d pv=%b wr=%0d expected %0d/0/%0d",
               idx, bus.pkt_valid, bus.cnt_write, int'(d.len) + 1, cnt0[63:48] + 16'd1);
    end
    bus.beat_ready = 1'b1;
  endtask

  task automatic test_back_to_back();
    desc_t       d1, d2;
    bit          t;
    logic [15:0] rd0, tot0;
    waitForAccess(1'b1, t);
    checks++;
    if (t) begin
      failures++;
      $display("[TB] FAIL b2b_find_read: timeout got 1 expected 0");
    end
    @(negedge ACLK);
    bus.gen_req = 1'b1;
    modelRequest(d1);
    d1 = descQ.pop_front();
    for (int c = 0; c < 5; c++) begin
      @(negedge ACLK);
      checks++;
      if (bus.pkt_valid !== 1'b1 || sampleDesc() !== d1) begin
        failures++;
        $display("[TB] FAIL b2b_hold cyc%0d: got pv=%b %h expected 1 %h", c, bus.pkt_valid, sampleDesc(), d1);
      end
    end
    rd0  = bus.cnt_read;
    tot0 = bus.cnt_inlimit + bus.cnt_outlimit;
    bus.pkt_ack = 1'b1;
    @(negedge ACLK);
    bus.pkt_ack = 1'b0;
    noteDone(d1);
    checks++;
    if ({bus.pkt_valid, bus.cnt_read, 16'(bus.cnt_inlimit + bus.cnt_outlimit)} !==
        {1'b0, rd0 + 16'd1, tot0 + 16'd1}) begin
      failures++;
      $display("[TB] FAIL b2b_one_count: got pv=%b rd=%0d tot=%0d expected 0/%0d/%0d", bus.pkt_valid,
               bus.cnt_read, 16'(bus.cnt_inlimit + bus.cnt_outlimit), rd0 + 16'd1, tot0 + 16'd1);
    end
    modelRequest(d2);
    d2 = descQ.pop_front();
    @(negedge ACLK);
    bus.gen_req = 1'b0;
    checks++;
    if (bus.pkt_valid !== 1'b1 || sampleDesc() !== d2) begin
      failures++;
      $display("[TB] FAIL b2b_next: got pv=%b %h expected 1 %h", bus.pkt_valid, sampleDesc(), d2);
    end
    finishPacket(d2, t);
    checks++;
    if (t || bus.pkt_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL b2b_finish: got timeout=%b pv=%b expected 0/0", t, bus.pkt_valid);
    end
  endtask

  task automatic test_saturation();
    desc_t d;
    bit    t;
    int    w, r, i, o;
    @(negedge ACLK);
    force dut.cntWrite_q    = 16'hFFFE;
    force dut.cntRead_q     = 16'hFFFE;
    force dut.cntInlimit_q  = 16'hFFFE;
    force dut.cntOutlimit_q = 16'hFFFE;
    #1;
    release dut.cntWrite_q;
    release dut.cntRead_q;
    release dut.cntInlimit_q;
    release dut.cntOutlimit_q;
    w = 0; r = 0; i = 0; o = 0;
    for (int n = 0; n < 3; n++) begin
      runPacket(d, t);
      checks++;
      if (t) begin
        failures++;
        $display("[TB] FAIL sat_run pkt%0d: timeout got 1 expected 0", n);
      end
      if (d.access) r++; else w++;
      if (d.inlimit) i++; else o++;
    end
    checks++;
    if (bus.cnt_write !== ((w >= 1) ? 16'hFFFF : 16'hFFFE) ||
        bus.cnt_read  !== ((r >= 1) ? 16'hFFFF : 16'hFFFE)) begin
      failures++;
      $display("[TB] FAIL sat_wr_rd: got %h %h expected %h %h", bus.cnt_write, bus.cnt_read,
               (w >= 1) ? 16'hFFFF : 16'hFFFE, (r >= 1) ? 16'hFFFF : 16'hFFFE);
    end
    checks++;
    if (bus.cnt_inlimit  !== ((i >= 1) ? 16'hFFFF : 16'hFFFE) ||
        bus.cnt_outlimit !== ((o >= 1) ? 16'hFFFF : 16'hFFFE)) begin
      failures++;
      $display("[TB] FAIL sat_in_out: got %h %h expected %h %h", bus.cnt_inlimit, bus.cnt_outlimit,
               (i >= 1) ? 16'hFFFF : 16'hFFFE, (o >= 1) ? 16'hFFFF : 16'hFFFE);
    end
  endtask

  initial begin
    test_reset();
    test_first_packet();
    test_random_packets();
    test_write_beats();
    test_early_ack();
    test_back_to_back();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule

// File: doc/axi_packet.md
Name: axi_packet

Overview:
- Synthesizable AXI4 stimulus generator that produces one randomized transaction descriptor per request.
- Each descriptor carries: access type, start address, burst length, burst size, in-limit flag and expected response. Write descriptors also stream their data beats.
- The block sits in the verification harness in front of the AXI4 master driver that exercises the memory-mapped slave.
- It also keeps saturating coverage counters.

Parameters:
- ADDR_WIDTH, 16, byte-address width.
- DATA_WIDTH, 32, beat width. Must be 32 for this revision.
- MEMORY_DEPTH, 1024, slave depth in 32-bit words. Must be a power of two, with MEMORY_DEPTH*8 <= 2**ADDR_WIDTH.
- SEED, 32'h1, LFSR reset value. A value of 0 is replaced by 1.

Ports:
- ACLK, in, 1, clock. All logic is on the rising edge.
- ARESET, in, 1, synchronous active-high reset.
- gen_req, in, 1, request a new packet. Honoured only in IDLE.
- pkt_valid, out, 1, descriptor fields are valid.
- pkt_ack, in, 1, consumer has finished with the packet.
- access, out, 1, 0 = write, 1 = read.
- addr, out, ADDR_WIDTH, byte start address. Always word aligned.
- len, out, 8, AXI LEN (beats - 1).
- size, out, 3, AXI SIZE. Constant 3'b010.
- inlimit, out, 1, 1 = legal in-range burst.
- exp_resp, out, 2, expected BRESP/RRESP.
- beat_valid, out, 1, write data beat available.
- beat_ready, in, 1, beat consumed.
- beat_data, out, 32, write data.
- beat_last, out, 1, final beat.
- cnt_write, out, 16, saturating coverage counter.
- cnt_read, out, 16, saturating coverage counter.
- cnt_inlimit, out, 16, saturating coverage counter.
- cnt_outlimit, out, 16, saturating coverage counter.

Behaviour:
- LFSR:
  - 32-bit Galois register. One step is: lsb = l[0]; l = l >> 1; if lsb, l ^= 32'h80200003.
  - The LFSR steps only where stated below.
- Reset:
  - LFSR = SEED (or 1 if SEED is 0); state = IDLE.
  - All outputs are 0, except size = 3'b010.
  - Reset mid-packet abandons the packet; the counters are not incremented.
- States: IDLE, PKT.
- IDLE with gen_req = 1:
  - Step the LFSR once and let r be the new value.
  - Latch the fields below; enter PKT and set pkt_valid = 1 on the next cycle.
  - Latency: 1 cycle.
- Field derivation from r:
  - access = r[0].
  - inlimit = (r[2:1] != 2'b00).
  - raw_len = r[11:4].
  - w = r[31:16] & (MEMORY_DEPTH-1).
- In-limit packets:
  - start word = w; len = raw_len, clamped so that w+len+1 <= MEMORY_DEPTH.
  - Also clamped so that (w mod 1024)+len+1 <= 1024, i.e. no 4 KB crossing. The smaller clamp wins.
  - exp_resp = 2'b00.
- Out-of-limit packets:
  - start word = MEMORY_DEPTH + w; len = raw_len.
  - exp_resp = 2'b10.
- In both cases addr = start word << 2, truncated to ADDR_WIDTH.
- Write packets in PKT:
  - beat_valid = 1, beat_data = current LFSR value.
  - beat_last = 1 when beat index == len.
  - On beat_valid & beat_ready: step the LFSR and increment the index.
  - After the last beat is accepted, beat_valid drops on the next cycle.
  - Exactly len+1 beats are produced.
- Read packets: beat_valid is never asserted.
- Packet completion:
  - pkt_ack is honoured when access = 1, or when all write beats have been accepted. It is ignored before that.
  - An accepted pkt_ack returns the block to IDLE, clears pkt_valid and increments cnt_write or cnt_read, plus cnt_inlimit or cnt_outlimit.
  - pkt_ack and the last-beat handshake in the same cycle count as complete.
- Holding and stall rules:
  - Descriptor fields stay stable while pkt_valid is high.
  - gen_req outside IDLE is ignored (not queued).
  - A new gen_req on the cycle after an ack is accepted normally.
- Counters saturate at 16'hFFFF; no wrap.

Test Plan:
- Reset check: assert ARESET for 2 cycles, then release.
  - All outputs are 0, size = 3'b010.
  - With SEED = 0, the first gen_req yields r = 32'h80200003 (the step from 1): access = 1, inlimit = 1, raw_len = 0, w = 16'h8020 & 1023 = 32, addr = 16'h0080, exp_resp = 00.
- Issue 200 packets, acking each.
  - Every in-limit packet: addr + 4*(len+1) <= 4096, no 4 KB crossing, exp_resp = 00.
  - Every out-limit packet: addr in [16'h1000, 16'h1FFC], exp_resp = 10.
- Write packet with len = N, beat_ready held high.
  - Exactly N+1 beats; beat_last only on beat N; each beat_data equals the successive LFSR steps.
- Write packet with pkt_ack asserted before the last beat.
  - pkt_valid stays 1 and the counters are unchanged.
  - pkt_ack with or after the last beat clears pkt_valid within 1 cycle.
- gen_req held high during PKT.
  - Descriptor fields are unchanged.
  - Only one packet is counted per ack.
- Force 70000 acks (or preload via reset-free run).
  - Counters stop at 16'hFFFF.
  - cnt_write + cnt_read equals cnt_inlimit + cnt_outlimit before saturation.
